// File: rtl/tx_serializer_10b_if.sv
// Symbol handshake between the 8b/10b encoder and the serializer.
// The encoder side is the master; the serializer is the slave.
interface tx_serializer_10b_if;
    logic [9:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;

    modport master (
        output sym_in,
        output sym_valid,
        input  sym_ready
    );

    modport slave (
        input  sym_in,
        input  sym_valid,
        output sym_ready
    );
endinterface

// File: rtl/tx_serializer_10b.sv
// 10-bit symbol serializer with one-deep hold buffer, K28.5 idle
// insertion and running-disparity tracking.
module tx_serializer_10b #(
    parameter logic [9:0] COMMA_NEG = 10'b0011111010,
    parameter logic [9:0] COMMA_POS = 10'b1100000101
) (
    input  logic                      clk,
    input  logic                      rst,
    tx_serializer_10b_if.slave        sym_if,
    output logic                      ser_out,
    output logic                      ser_frame,
    output logic                      idle_active,
    output logic                      rd_state,
    output logic                      disp_err,
    output logic [15:0]               idle_count
);

    logic [9:0]  shift_q, shift_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [9:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        rd_q, rd_d;
    logic        disp_err_q, disp_err_d;
    logic [15:0] idle_count_q, idle_count_d;
    logic        idle_active_q, idle_active_d;

    logic        load_now;
    logic        accept;
    logic [9:0]  load_word;
    logic [3:0]  pop;

    assign load_now         = (bit_cnt_q == 4'd9);
    assign sym_if.sym_ready = !hold_full_q || load_now;
    assign accept           = sym_if.sym_valid && sym_if.sym_ready;

    assign ser_out     = shift_q[9];
    assign ser_frame   = (bit_cnt_q == 4'd0);
    assign idle_active = idle_active_q;
    assign rd_state    = rd_q;
    assign disp_err    = disp_err_q;
    assign idle_count  = idle_count_q;

    // Next state: shift/count every cycle, pick the next word at a load edge.
    always_comb begin
        shift_d       = {shift_q[8:0], 1'b0};
        bit_cnt_d     = bit_cnt_q + 4'd1;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        rd_d          = rd_q;
        disp_err_d    = disp_err_q;
        idle_count_d  = idle_count_q;
        idle_active_d = idle_active_q;
        load_word     = '0;
        pop           = '0;

        if (load_now) begin
            bit_cnt_d = 4'd0;
            if (hold_full_q) begin
                load_word     = hold_q;
                idle_active_d = 1'b0;
                if (accept) begin
                    hold_d = sym_if.sym_in;
                end else begin
                    hold_full_d = 1'b0;
                end
            end else if (accept) begin
                load_word     = sym_if.sym_in;
                idle_active_d = 1'b0;
            end else begin
                load_word     = rd_q ? COMMA_POS : COMMA_NEG;
                idle_active_d = 1'b1;
                if (idle_count_q != 16'hFFFF) begin
                    idle_count_d = idle_count_q + 16'd1;
                end
            end
            shift_d = load_word;

            for (int i = 0; i < 10; i++) begin
                pop = pop + {3'b000, load_word[i]};
            end

            // A 6-ones word must follow negative RD, a 4-ones word
            // positive RD; anything outside 4..6 is never legal.
            unique case (1'b1)
                (pop == 4'd6): begin
                    rd_d = 1'b1;
                    if (rd_q) disp_err_d = 1'b1;
                end
                (pop == 4'd4): begin
                    rd_d = 1'b0;
                    if (!rd_q) disp_err_d = 1'b1;
                end
                (pop == 4'd5): begin
                end
                default: begin
                    disp_err_d = 1'b1;
                end
            endcase
        end else if (accept) begin
            hold_d      = sym_if.sym_in;
            hold_full_d = 1'b1;
        end
    end

    // State registers; reset also drops any held or partial symbol.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q       <= '0;
            bit_cnt_q     <= 4'd9;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            rd_q          <= 1'b0;
            disp_err_q    <= 1'b0;
            idle_count_q  <= '0;
            idle_active_q <= 1'b0;
        end else begin
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            rd_q          <= rd_d;
            disp_err_q    <= disp_err_d;
            idle_count_q  <= idle_count_d;
            idle_active_q <= idle_active_d;
        end
    end

endmodule

// File: tb/tb_tx_serializer_10b.sv
// Scoreboard bench for tx_serializer_10b: stimulus queues expected
// symbols, a negedge monitor reassembles serial frames and compares.
module tb_tx_serializer_10b;

    localparam logic [9:0] NEG  = 10'b0011111010;
    localparam logic [9:0] POS  = 10'b1100000101;
    localparam logic [9:0] D215 = 10'b1010101010;
    localparam logic [9:0] SA   = 10'b1001110100;
    localparam logic [9:0] SB   = 10'b0110001011;
    localparam logic [9:0] SD   = 10'b0101010101;
    localparam logic [9:0] ONES = 10'b1111111111;
    localparam logic [9:0] P6   = 10'b1110001101;

    typedef struct {
        logic [9:0] w;
        logic       idle;
        logic       rd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ser_out;
    logic        ser_frame;
    logic        idle_active;
    logic        rd_state;
    logic        disp_err;
    logic [15:0] idle_count;

    int compared;
    int mismatched;
    exp_t exp_q[$];

    tx_serializer_10b_if sif();

    tx_serializer_10b dut (
        .clk         (clk),
        .rst         (rst),
        .sym_if      (sif),
        .ser_out     (ser_out),
        .ser_frame   (ser_frame),
        .idle_active (idle_active),
        .rd_state    (rd_state),
        .disp_err    (disp_err),
        .idle_count  (idle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic void expect_sym(input logic [9:0] w,
                                       input logic idle, input logic rd);
        exp_t e;
        e.w = w;
        e.idle = idle;
        e.rd = rd;
        exp_q.push_back(e);
    endfunction

    // Monitor: rebuild each frame starting at ser_frame.
    logic [9:0] col_w;
    int         col_n;
    logic       col_idle;
    logic       col_rd;

    initial col_n = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            col_n = 0;
        end else if (ser_frame) begin
            col_w    = {9'b0, ser_out};
            col_n    = 1;
            col_idle = idle_active;
            col_rd   = rd_state;
        end else if (col_n > 0) begin
            col_w = {col_w[8:0], ser_out};
            col_n++;
            if (col_n == 10) begin
                col_n = 0;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sym_word", {22'b0, col_w}, {22'b0, e.w});
                    check("sym_idle", {31'b0, col_idle}, {31'b0, e.idle});
                    check("sym_rd", {31'b0, col_rd}, {31'b0, e.rd});
                end
            end
        end
    end

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic start_reset();
        @(negedge clk);
        rst = 1'b1;
        sif.sym_valid = 1'b0;
        sif.sym_in = '0;
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Call at a negedge; returns just after the accepting posedge.
    task automatic send(input logic [9:0] s, output int waits);
        logic r;
        waits = 0;
        sif.sym_in = s;
        sif.sym_valid = 1'b1;
        forever begin
            r = sif.sym_ready;
            @(posedge clk);
            if (r) break;
            waits++;
            if (waits > 30) begin
                compared++;
                mismatched++;
                $display("FAIL send_timeout: got %0d waits, required <31", waits);
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int w;
        compared = 0;
        mismatched = 0;
        rst = 1'b1;
        sif.sym_valid = 1'b0;
        sif.sym_in = '0;

        // Idle stream after reset.
        start_reset();
        check("rst_ser_out", {31'b0, ser_out}, 0);
        check("rst_ser_frame", {31'b0, ser_frame}, 0);
        check("rst_ready", {31'b0, sif.sym_ready}, 1);
        check("rst_rd", {31'b0, rd_state}, 0);
        check("rst_err", {31'b0, disp_err}, 0);
        check("rst_idle_cnt", {16'b0, idle_count}, 0);
        check("rst_idle_act", {31'b0, idle_active}, 0);
        expect_sym(NEG, 1'b1, 1'b1);
        expect_sym(POS, 1'b1, 1'b0);
        expect_sym(NEG, 1'b1, 1'b1);
        expect_sym(POS, 1'b1, 1'b0);
        release_reset();
        repeat (40) @(posedge clk);
        #1;
        check("idle_cnt_40", {16'b0, idle_count}, 4);
        check("idle_err", {31'b0, disp_err}, 0);
        wait_drain(40);

        // Bypass at first load, then comma after valid drops.
        start_reset();
        sif.sym_in = D215;
        sif.sym_valid = 1'b1;
        check("rst_ready_v", {31'b0, sif.sym_ready}, 1);
        expect_sym(D215, 1'b0, 1'b0);
        expect_sym(NEG, 1'b1, 1'b1);
        release_reset();
        send(D215, w);
        check("bypass_wait", w, 0);
        #1;
        sif.sym_valid = 1'b0;
        check("bypass_frame", {31'b0, ser_frame}, 1);
        check("bypass_bit9", {31'b0, ser_out}, 1);
        check("bypass_idle", {31'b0, idle_active}, 0);
        wait_drain(40);

        // Back-to-back stream through the hold buffer.
        start_reset();
        sif.sym_in = SA;
        sif.sym_valid = 1'b1;
        expect_sym(SA, 1'b0, 1'b0);
        expect_sym(SB, 1'b0, 1'b0);
        expect_sym(D215, 1'b0, 1'b0);
        expect_sym(SD, 1'b0, 1'b0);
        expect_sym(NEG, 1'b1, 1'b1);
        release_reset();
        send(SA, w);
        @(negedge clk);
        send(SB, w);
        check("b2b_wait_b", w, 0);
        @(negedge clk);
        send(D215, w);
        check("b2b_wait_c", w, 8);
        @(negedge clk);
        send(SD, w);
        check("b2b_wait_d", w, 9);
        #1;
        sif.sym_valid = 1'b0;
        check("b2b_idle_cnt", {16'b0, idle_count}, 0);
        wait_drain(60);
        check("b2b_err", {31'b0, disp_err}, 0);

        // Illegal all-ones word: sticky error.
        start_reset();
        sif.sym_in = ONES;
        sif.sym_valid = 1'b1;
        expect_sym(ONES, 1'b0, 1'b0);
        expect_sym(NEG, 1'b1, 1'b1);
        release_reset();
        send(ONES, w);
        #1;
        sif.sym_valid = 1'b0;
        check("ones_err", {31'b0, disp_err}, 1);
        wait_drain(40);
        check("ones_err_sticky", {31'b0, disp_err}, 1);

        // Two 6-ones words in a row: error on the second load.
        start_reset();
        check("err_cleared", {31'b0, disp_err}, 0);
        sif.sym_in = P6;
        sif.sym_valid = 1'b1;
        expect_sym(P6, 1'b0, 1'b1);
        expect_sym(P6, 1'b0, 1'b1);
        expect_sym(POS, 1'b1, 1'b0);
        release_reset();
        send(P6, w);
        @(negedge clk);
        send(P6, w);
        #1;
        sif.sym_valid = 1'b0;
        check("p6_err_first", {31'b0, disp_err}, 0);
        repeat (8) @(posedge clk);
        #1;
        check("p6_err_before", {31'b0, disp_err}, 0);
        @(posedge clk);
        #1;
        check("p6_err_after", {31'b0, disp_err}, 1);
        wait_drain(40);

        // Reset mid-symbol with the hold buffer full.
        start_reset();
        sif.sym_in = SA;
        sif.sym_valid = 1'b1;
        release_reset();
        send(SA, w);
        @(negedge clk);
        send(SB, w);
        #1;
        sif.sym_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_ser_out", {31'b0, ser_out}, 0);
        check("mid_frame", {31'b0, ser_frame}, 0);
        check("mid_ready", {31'b0, sif.sym_ready}, 1);
        check("mid_rd", {31'b0, rd_state}, 0);
        check("mid_idle_act", {31'b0, idle_active}, 0);
        @(posedge clk);
        #1;
        check("mid_frame_cyc", {31'b0, ser_frame}, 0);
        expect_sym(NEG, 1'b1, 1'b1);
        expect_sym(POS, 1'b1, 1'b0);
        release_reset();
        wait_drain(40);
        check("mid_idle_cnt", {16'b0, idle_count}, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
